// File: rtl/decode_queue.sv
// RV32I decode queue: decodes fetched instructions on enqueue and buffers them,
// with their PC, in a DEPTH-entry circular FIFO toward dispatch.

`ifndef DECODE_QUEUE_OPS
`define DECODE_QUEUE_OPS
`define OP_LUI   8'd1
`define OP_AUIPC 8'd2
`define OP_JAL   8'd3
`define OP_JALR  8'd4
`define OP_BEQ   8'd5
`define OP_BNE   8'd6
`define OP_BLT   8'd7
`define OP_BGE   8'd8
`define OP_BLTU  8'd9
`define OP_BGEU  8'd10
`define OP_LB    8'd11
`define OP_LH    8'd12
`define OP_LW    8'd13
`define OP_LBU   8'd14
`define OP_LHU   8'd15
`define OP_SB    8'd16
`define OP_SH    8'd17
`define OP_SW    8'd18
`define OP_ADDI  8'd19
`define OP_SLTI  8'd20
`define OP_SLTIU 8'd21
`define OP_XORI  8'd22
`define OP_ORI   8'd23
`define OP_ANDI  8'd24
`define OP_SLLI  8'd25
`define OP_SRLI  8'd26
`define OP_SRAI  8'd27
`define OP_ADD   8'd28
`define OP_SUB   8'd29
`define OP_SLL   8'd30
`define OP_SLT   8'd31
`define OP_SLTU  8'd32
`define OP_XOR   8'd33
`define OP_SRL   8'd34
`define OP_SRA   8'd35
`define OP_OR    8'd36
`define OP_AND   8'd37
`endif

module decode_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned OP_W   = 6
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         flush_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_ins,
    input  logic [ADDR_W-1:0]            in_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OP_W-1:0]              out_opcode,
    output logic [4:0]                   out_rd,
    output logic [4:0]                   out_rs1,
    output logic [4:0]                   out_rs2,
    output logic [31:0]                  out_imm,
    output logic [ADDR_W-1:0]            out_pc,
    output logic                         out_illegal,
    output logic [$clog2(DEPTH+1)-1:0]   out_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned EW = 1 + OP_W + 15 + 32 + ADDR_W;

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head_ent;
    logic          push, pop;

    // Instruction fields and immediate formats
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic [7:0]  op_n;
    logic [4:0]  d_rd, d_rs1, d_rs2;
    logic [31:0] d_imm;
    logic        d_ill;

    assign f3     = in_ins[14:12];
    assign f7     = in_ins[31:25];
    assign imm_i  = {{20{in_ins[31]}}, in_ins[31:20]};
    assign imm_s  = {{20{in_ins[31]}}, in_ins[31:25], in_ins[11:7]};
    assign imm_b  = {{19{in_ins[31]}}, in_ins[31], in_ins[7], in_ins[30:25], in_ins[11:8], 1'b0};
    assign imm_u  = {in_ins[31:12], 12'b0};
    assign imm_j  = {{11{in_ins[31]}}, in_ins[31], in_ins[19:12], in_ins[20], in_ins[30:21],
                     1'b0};
    assign imm_sh = {27'b0, in_ins[24:20]};

    // Decode the incoming word; op_n == 0 marks an illegal encoding
    always_comb begin
        op_n  = 8'd0;
        d_rd  = 5'd0;
        d_rs1 = 5'd0;
        d_rs2 = 5'd0;
        d_imm = 32'd0;
        case (in_ins[6:0])
            7'h37: begin op_n = `OP_LUI;   d_rd = in_ins[11:7]; d_imm = imm_u; end
            7'h17: begin op_n = `OP_AUIPC; d_rd = in_ins[11:7]; d_imm = imm_u; end
            7'h6f: begin op_n = `OP_JAL;   d_rd = in_ins[11:7]; d_imm = imm_j; end
            7'h67: begin
                if (f3 == 3'b000) op_n = `OP_JALR;
                d_rd  = in_ins[11:7];
                d_rs1 = in_ins[19:15];
                d_imm = imm_i;
            end
            7'h63: begin
                case (f3)
                    3'b000:  op_n = `OP_BEQ;
                    3'b001:  op_n = `OP_BNE;
                    3'b100:  op_n = `OP_BLT;
                    3'b101:  op_n = `OP_BGE;
                    3'b110:  op_n = `OP_BLTU;
                    3'b111:  op_n = `OP_BGEU;
                    default: op_n = 8'd0;
                endcase
                d_rs1 = in_ins[19:15];
                d_rs2 = in_ins[24:20];
                d_imm = imm_b;
            end
            7'h03: begin
                case (f3)
                    3'b000:  op_n = `OP_LB;
                    3'b001:  op_n = `OP_LH;
                    3'b010:  op_n = `OP_LW;
                    3'b100:  op_n = `OP_LBU;
                    3'b101:  op_n = `OP_LHU;
                    default: op_n = 8'd0;
                endcase
                d_rd  = in_ins[11:7];
                d_rs1 = in_ins[19:15];
                d_imm = imm_i;
            end
            7'h23: begin
                case (f3)
                    3'b000:  op_n = `OP_SB;
                    3'b001:  op_n = `OP_SH;
                    3'b010:  op_n = `OP_SW;
                    default: op_n = 8'd0;
                endcase
                d_rs1 = in_ins[19:15];
                d_rs2 = in_ins[24:20];
                d_imm = imm_s;
            end
            7'h13: begin
                d_rd  = in_ins[11:7];
                d_rs1 = in_ins[19:15];
                d_imm = imm_i;
                case (f3)
                    3'b000: op_n = `OP_ADDI;
                    3'b010: op_n = `OP_SLTI;
                    3'b011: op_n = `OP_SLTIU;
                    3'b100: op_n = `OP_XORI;
                    3'b110: op_n = `OP_ORI;
                    3'b111: op_n = `OP_ANDI;
                    3'b001: begin
                        d_imm = imm_sh;
                        if (f7 == 7'b0000000) op_n = `OP_SLLI;
                    end
                    default: begin
                        d_imm = imm_sh;
                        if (f7 == 7'b0000000)      op_n = `OP_SRLI;
                        else if (f7 == 7'b0100000) op_n = `OP_SRAI;
                    end
                endcase
            end
            7'h33: begin
                d_rd  = in_ins[11:7];
                d_rs1 = in_ins[19:15];
                d_rs2 = in_ins[24:20];
                case ({f7, f3})
                    {7'b0000000, 3'b000}: op_n = `OP_ADD;
                    {7'b0100000, 3'b000}: op_n = `OP_SUB;
                    {7'b0000000, 3'b001}: op_n = `OP_SLL;
                    {7'b0000000, 3'b010}: op_n = `OP_SLT;
                    {7'b0000000, 3'b011}: op_n = `OP_SLTU;
                    {7'b0000000, 3'b100}: op_n = `OP_XOR;
                    {7'b0000000, 3'b101}: op_n = `OP_SRL;
                    {7'b0100000, 3'b101}: op_n = `OP_SRA;
                    {7'b0000000, 3'b110}: op_n = `OP_OR;
                    {7'b0000000, 3'b111}: op_n = `OP_AND;
                    default:              op_n = 8'd0;
                endcase
            end
            default: op_n = 8'd0;
        endcase
        d_ill = (op_n == 8'd0);
        // Illegal entries carry only the flag and PC
        if (d_ill) begin
            d_rd  = 5'd0;
            d_rs1 = 5'd0;
            d_rs2 = 5'd0;
            d_imm = 32'd0;
        end
    end

    assign in_ready  = rdy_in & (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush_in;
    assign pop       = out_valid & out_ready & rdy_in & ~flush_in;

    // Pointer and occupancy update; flush outranks push/pop, rdy_in low freezes all
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (!push && pop) count <= count - 1'b1;
            end
        end
    end

    // Entry storage; contents only matter while counted as occupied
    always_ff @(posedge clk_in) begin
        if (push) mem[tail] <= {d_ill, OP_W'(op_n), d_rd, d_rs1, d_rs2, d_imm, in_pc};
    end

    assign head_ent  = out_valid ? mem[head] : '0;
    assign {out_illegal, out_opcode, out_rd, out_rs1, out_rs2, out_imm, out_pc} = head_ent;
    assign out_count = count;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed steps plus randomized traffic
// checked against a queue-based reference model.

module tb_decode_queue;

    localparam int DEPTH = 4;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        flush_in = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_ins = 32'd0;
    logic [31:0] in_pc = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic        out_illegal;
    logic [2:0]  out_count;

    decode_queue dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .flush_in   (flush_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ins     (in_ins),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_rd     (out_rd),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_imm    (out_imm),
        .out_pc     (out_pc),
        .out_illegal(out_illegal),
        .out_count  (out_count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic        ill;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } dec_t;

    // Opcode numbering shared with dispatch; 0 means illegal
    localparam int OP_ADDI = 19, OP_SW = 18, OP_SRAI = 27, OP_BEQ = 5;

    int br_tab[8] = '{5, 6, 0, 0, 7, 8, 9, 10};
    int ld_tab[8] = '{11, 12, 13, 0, 14, 15, 0, 0};
    int st_tab[8] = '{16, 17, 18, 0, 0, 0, 0, 0};
    int oi_tab[8] = '{19, 0, 20, 21, 22, 0, 23, 24};
    int r0_tab[8] = '{28, 30, 31, 32, 33, 34, 36, 37};
    int r1_tab[8] = '{29, 0, 0, 0, 0, 35, 0, 0};

    dec_t mq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference decoder: pick opcode from tables, then fill fields by format
    function automatic dec_t ref_dec(input logic [31:0] w, input logic [31:0] pc);
        dec_t d;
        int   op, fmt, f3, f7, imm;
        d   = '0;
        op  = 0;
        fmt = 0;
        imm = 0;
        f3  = int'(w[14:12]);
        f7  = int'(w[31:25]);
        case (w[6:0])
            7'h37: begin op = 1; fmt = 1; end
            7'h17: begin op = 2; fmt = 1; end
            7'h6f: begin op = 3; fmt = 2; end
            7'h67: begin op = (f3 == 0) ? 4 : 0; fmt = 3; end
            7'h63: begin op = br_tab[f3]; fmt = 4; end
            7'h03: begin op = ld_tab[f3]; fmt = 3; end
            7'h23: begin op = st_tab[f3]; fmt = 5; end
            7'h13: begin
                if (f3 == 1) begin op = (f7 == 0) ? 25 : 0; fmt = 6; end
                else if (f3 == 5) begin
                    op  = (f7 == 0) ? 26 : (f7 == 32) ? 27 : 0;
                    fmt = 6;
                end else begin op = oi_tab[f3]; fmt = 3; end
            end
            7'h33: begin
                op  = (f7 == 0) ? r0_tab[f3] : (f7 == 32) ? r1_tab[f3] : 0;
                fmt = 7;
            end
            default: op = 0;
        endcase
        d.pc = pc;
        if (op == 0) begin
            d.ill = 1'b1;
            return d;
        end
        d.op = 6'(op);
        case (fmt)
            1: begin d.rd = w[11:7]; imm = int'(w & 32'hFFFFF000); end
            2: begin
                d.rd = w[11:7];
                imm = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2
                      - (w[31] ? 1048576 : 0);
            end
            3: begin
                d.rd = w[11:7]; d.rs1 = w[19:15];
                imm = int'(w[31:20]) - (w[31] ? 4096 : 0);
            end
            4: begin
                d.rs1 = w[19:15]; d.rs2 = w[24:20];
                imm = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2
                      - (w[31] ? 4096 : 0);
            end
            5: begin
                d.rs1 = w[19:15]; d.rs2 = w[24:20];
                imm = int'(w[31:25]) * 32 + int'(w[11:7]) - (w[31] ? 4096 : 0);
            end
            6: begin d.rd = w[11:7]; d.rs1 = w[19:15]; imm = int'(w[24:20]); end
            default: begin d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20]; end
        endcase
        d.imm = imm;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        dec_t e;
        e = (mq.size() != 0) ? mq[0] : '0;
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(rdy_in && mq.size() < DEPTH));
        chk("out_count", 64'(out_count), 64'(mq.size()));
        chk("out_opcode", 64'(out_opcode), 64'(e.op));
        chk("out_rd", 64'(out_rd), 64'(e.rd));
        chk("out_rs1", 64'(out_rs1), 64'(e.rs1));
        chk("out_rs2", 64'(out_rs2), 64'(e.rs2));
        chk("out_imm", 64'(out_imm), 64'(e.imm));
        chk("out_pc", 64'(out_pc), 64'(e.pc));
        chk("out_illegal", 64'(out_illegal), 64'(e.ill));
    endtask

    // Advance the model by one edge from the current inputs, clock, then check
    task automatic tick();
        bit push, pop;
        if (rdy_in) begin
            if (flush_in) mq.delete();
            else begin
                push = in_valid && (mq.size() < DEPTH);
                pop  = out_ready && (mq.size() != 0);
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back(ref_dec(in_ins, in_pc));
            end
        end
        @(posedge clk_in);
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] w;
        logic [6:0]  opc[10];
        opc = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        w = $urandom;
        if ($urandom_range(0, 9) != 0) w[6:0] = opc[$urandom_range(0, 9)];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'b0000000;
            1: w[31:25] = 7'b0100000;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        // Reset state
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        check_all();
        rst_in = 1'b1;

        // Directed decodes, chained so each new word becomes the head
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ins = 32'h00500093; in_pc = 32'h0;
        tick();
        chk("addi_op", 64'(out_opcode), 64'(OP_ADDI));
        chk("addi_imm", 64'(out_imm), 64'd5);
        chk("addi_rd", 64'(out_rd), 64'd1);
        in_ins = 32'h0020A423; in_pc = 32'h4;
        tick();
        chk("sw_op", 64'(out_opcode), 64'(OP_SW));
        chk("sw_imm", 64'(out_imm), 64'd8);
        chk("sw_rs2", 64'(out_rs2), 64'd2);
        in_ins = 32'h4021D193; in_pc = 32'h8;
        tick();
        chk("srai_op", 64'(out_opcode), 64'(OP_SRAI));
        chk("srai_imm", 64'(out_imm), 64'd2);
        in_ins = 32'hFE000EE3; in_pc = 32'hC;
        tick();
        chk("beq_op", 64'(out_opcode), 64'(OP_BEQ));
        chk("beq_imm", 64'(out_imm), 64'hFFFFFFFC);
        in_ins = 32'h00000000; in_pc = 32'h100;
        tick();
        chk("ill_flag", 64'(out_illegal), 64'd1);
        chk("ill_pc", 64'(out_pc), 64'h100);
        in_valid = 1'b0;
        tick();

        // Fill to DEPTH, then overflow attempt, then streaming across wrap
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            in_ins = rand_ins(); in_pc = 32'h200 + 32'(4 * i);
            tick();
        end
        chk("full_count", 64'(out_count), 64'd4);
        chk("full_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_ins = rand_ins(); in_pc = 32'h300 + 32'(4 * i);
            tick();
        end

        // Flush with concurrent push and pop
        in_valid = 1'b0;
        for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_ins = rand_ins(); in_pc = 32'h400 + 32'(4 * i);
            tick();
        end
        flush_in = 1'b1; out_ready = 1'b1;
        in_ins = 32'h00500093; in_pc = 32'h500;
        tick();
        chk("flush_count", 64'(out_count), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        flush_in = 1'b0;

        // Asynchronous reset with entries queued
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_ins = rand_ins(); in_pc = 32'h600 + 32'(4 * i);
            tick();
        end
        in_valid = 1'b0;
        #2 rst_in = 1'b0;
        #1;
        mq.delete();
        chk("arst_valid", 64'(out_valid), 64'd0);
        check_all();
        rst_in = 1'b1;

        // rdy_in low freezes the queue
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_ins = rand_ins(); in_pc = 32'h700 + 32'(4 * i);
            tick();
        end
        rdy_in = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_ins = rand_ins();
            flush_in = (i == 1);
            tick();
        end
        flush_in = 1'b0;
        chk("stall_count", 64'(out_count), 64'd2);
        rdy_in = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rdy_in    = ($urandom_range(0, 7) != 0);
            flush_in  = ($urandom_range(0, 29) == 0);
            in_ins    = rand_ins();
            in_pc     = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
